// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Converts a single-outstanding valid/ready request into an APB3 SETUP/ACCESS
// transfer and returns read data / error on a valid/ready response channel.
// A slave that holds PREADY_i low for TIMEOUT ACCESS cycles is aborted with
// an error response.
module apb_master_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  PCLK_i,
  input  logic                  PRST_i,
  // request channel
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  // response channel
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  // APB master side
  output logic                  PSEL_o,
  output logic                  PENABLE_o,
  output logic                  PWRITE_o,
  output logic [ADDR_WIDTH-1:0] PADDR_o,
  output logic [DATA_WIDTH-1:0] PWDATA_o,
  input  logic [DATA_WIDTH-1:0] PRDATA_i,
  input  logic                  PREADY_i,
  input  logic                  PSLVERR_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // Count value seen in the last permitted ACCESS cycle with PREADY_i low.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;

  // Main FSM; every output is a register so the APB side sees glitch-free
  // controls. req_ready_o is registered too, which is why it reads 0 in the
  // cycle that follows a reset edge and rises one cycle later.
  always_ff @(posedge PCLK_i) begin
    if (PRST_i) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      PSEL_o      <= 1'b0;
      PENABLE_o   <= 1'b0;
      PWRITE_o    <= 1'b0;
      PADDR_o     <= '0;
      PWDATA_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready_o && req_valid_i) begin
            PWRITE_o    <= req_write_i;
            PADDR_o     <= req_addr_i;
            PWDATA_o    <= req_wdata_i;
            PSEL_o      <= 1'b1;
            req_ready_o <= 1'b0;
            state       <= SETUP;
          end else begin
            req_ready_o <= 1'b1;
          end
        end

        SETUP: begin
          PENABLE_o <= 1'b1;
          wait_cnt  <= '0;
          state     <= ACCESS;
        end

        ACCESS: begin
          if (PREADY_i) begin
            // Completion takes priority over a timeout in the same cycle.
            rsp_rdata_o <= PWRITE_o ? '0 : PRDATA_i;
            rsp_err_o   <= PSLVERR_i;
            rsp_valid_o <= 1'b1;
            PSEL_o      <= 1'b0;
            PENABLE_o   <= 1'b0;
            state       <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            PSEL_o      <= 1'b0;
            PENABLE_o   <= 1'b0;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
